// File: rtl/reaction_ctrl_pkg.sv
// Shared types and helpers for the reaction-time controller: FSM states,
// LFSR geometry and the millisecond counter width derivation.
package reaction_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_REACT = 3'd3,
    ST_SHOW  = 3'd4,
    ST_FOUL  = 3'd5
  } state_e;

  localparam int LFSR_W     = 11;
  localparam int LFSR_RND_W = 10;
  // Taps for x^11 + x^9 + 1, as bit indices of an 11-bit shift register
  localparam int LFSR_TAP_A = 10;
  localparam int LFSR_TAP_B = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 11'h001;

  function automatic int ms_width(input int max_ms);
    return $clog2(max_ms);
  endfunction

  function automatic int presc_width(input int clks_per_ms);
    return (clks_per_ms > 1) ? $clog2(clks_per_ms) : 1;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
  endfunction

  function automatic int unsigned sat_delay(
    input int unsigned           min_ms,
    input logic [LFSR_RND_W-1:0] rnd,
    input int unsigned           max_ms
  );
    int unsigned sum;
    sum = min_ms + 32'(rnd);
    return (sum > max_ms) ? max_ms : sum;
  endfunction

endpackage

// File: rtl/reaction_ctrl_lfsr11.sv
// Free-running 11-bit maximal-length LFSR; exposes the low bits of the value
// it will hold after the next clock edge.
module lfsr11
  import reaction_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  output logic [LFSR_RND_W-1:0] rnd_next_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic [LFSR_W-1:0] stepped_s;

  // Next state; a zero state can only come from an upset, so reseed from it
  always_comb begin
    stepped_s = lfsr_step(lfsr_q);
    if (stepped_s == '0) begin
      lfsr_d = LFSR_SEED;
    end else begin
      lfsr_d = stepped_s;
    end
  end

  assign rnd_next_o = lfsr_d[LFSR_RND_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: arms an external countdown with a random
// delay, lights the lamp when it expires and measures the press latency in ms.
module reaction_ctrl
  import reaction_ctrl_pkg::*;
#(
  parameter int MAX_MS       = 2047,
  parameter int CLKS_PER_MS  = 50000,
  parameter int MIN_DELAY_MS = 500,
  localparam int W           = ms_width(MAX_MS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         button,
  input  logic [W-1:0] timer_value,
  output logic         timer_stop,
  output logic         timer_enable,
  output logic [W-1:0] timer_start,
  output logic         led_on,
  output logic [W-1:0] reaction_ms,
  output logic         result_valid,
  output logic         too_early,
  output logic         timeout
);

  localparam int PW                 = presc_width(CLKS_PER_MS);
  localparam logic [W-1:0]  MAX_MS_W   = W'(MAX_MS);
  localparam logic [W-1:0]  MS_ONE     = W'(1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_MS - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  state_e         state_q, state_d;
  logic [W-1:0]   ms_q, ms_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           timer_stop_q, timer_stop_d;
  logic           timer_enable_q, timer_enable_d;
  logic [W-1:0]   timer_start_q, timer_start_d;
  logic           led_on_q, led_on_d;
  logic [W-1:0]   reaction_ms_q, reaction_ms_d;
  logic           result_valid_q, result_valid_d;
  logic           too_early_q, too_early_d;
  logic           timeout_q, timeout_d;

  logic [LFSR_RND_W-1:0] rnd_next_s;
  logic [W-1:0]          delay_s;

  lfsr11 u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .rnd_next_o (rnd_next_s)
  );

  // rnd_next_s is the LFSR value that will be current during the ARM cycle
  assign delay_s = W'(sat_delay(MIN_DELAY_MS, rnd_next_s, MAX_MS));

  // Next-state, measurement and output decode
  always_comb begin
    state_d        = state_q;
    ms_d           = '0;
    presc_d        = '0;
    reaction_ms_d  = reaction_ms_q;
    result_valid_d = 1'b0;
    timeout_d      = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (button) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (button) begin
          state_d = ST_FOUL;
        end else if (timer_value == '0) begin
          state_d = ST_REACT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_REACT: begin
        if (button) begin
          reaction_ms_d  = ms_q;
          result_valid_d = 1'b1;
          timeout_d      = 1'b0;
          state_d        = ST_SHOW;
        end else if (ms_q >= MAX_MS_W) begin
          reaction_ms_d  = MAX_MS_W;
          result_valid_d = 1'b1;
          timeout_d      = 1'b1;
          state_d        = ST_SHOW;
        end else begin
          state_d = ST_REACT;
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            ms_d    = ms_q + MS_ONE;
          end else begin
            presc_d = presc_q + PRESC_ONE;
            ms_d    = ms_q;
          end
        end
      end
      ST_SHOW: begin
        if (button) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b0;
        end else begin
          state_d = ST_SHOW;
        end
      end
      ST_FOUL: begin
        if (button) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FOUL;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        timeout_d = 1'b0;
      end
    endcase

    // Registered outputs follow the state being entered
    timer_stop_d   = (state_d == ST_ARM);
    timer_enable_d = (state_d == ST_WAIT);
    led_on_d       = (state_d == ST_REACT);
    too_early_d    = (state_d == ST_FOUL);
    if (state_d == ST_ARM) begin
      timer_start_d = delay_s;
    end else begin
      timer_start_d = timer_start_q;
    end
  end

  // State, measurement and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ms_q           <= '0;
      presc_q        <= '0;
      timer_stop_q   <= 1'b0;
      timer_enable_q <= 1'b0;
      timer_start_q  <= '0;
      led_on_q       <= 1'b0;
      reaction_ms_q  <= '0;
      result_valid_q <= 1'b0;
      too_early_q    <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ms_q           <= ms_d;
      presc_q        <= presc_d;
      timer_stop_q   <= timer_stop_d;
      timer_enable_q <= timer_enable_d;
      timer_start_q  <= timer_start_d;
      led_on_q       <= led_on_d;
      reaction_ms_q  <= reaction_ms_d;
      result_valid_q <= result_valid_d;
      too_early_q    <= too_early_d;
      timeout_q      <= timeout_d;
    end
  end

  assign timer_stop   = timer_stop_q;
  assign timer_enable = timer_enable_q;
  assign timer_start  = timer_start_q;
  assign led_on       = led_on_q;
  assign reaction_ms  = reaction_ms_q;
  assign result_valid = result_valid_q;
  assign too_early    = too_early_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Scoreboard bench for reaction_ctrl with a small countdown-timer model and
// an independent LFSR model predicting every timer_start value.
module tb_reaction_ctrl;

  localparam int MAX_MS = 63;
  localparam int CPM    = 4;
  localparam int MIND   = 2;
  localparam int W      = 6;

  typedef struct {
    int ms;
    int to;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         button;
  logic [W-1:0] timer_value;
  logic         timer_stop, timer_enable, led_on, result_valid, too_early, timeout;
  logic [W-1:0] timer_start, reaction_ms;

  int   total = 0;
  int   bad   = 0;
  int   arm_q[$];
  res_t res_q[$];
  logic led_forbid = 1'b0;
  logic [10:0] m_lfsr;
  logic [1:0]  m_presc;

  reaction_ctrl #(.MAX_MS(MAX_MS), .CLKS_PER_MS(CPM), .MIN_DELAY_MS(MIND)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .button       (button),
    .timer_value  (timer_value),
    .timer_stop   (timer_stop),
    .timer_enable (timer_enable),
    .timer_start  (timer_start),
    .led_on       (led_on),
    .reaction_ms  (reaction_ms),
    .result_valid (result_valid),
    .too_early    (too_early),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] m_step(input logic [10:0] s);
    return {s[9:0], s[10] ^ s[8]};
  endfunction

  function automatic int exp_start(input logic [10:0] cur);
    logic [10:0] nxt;
    int s;
    nxt = m_step(cur);
    s = MIND + int'(nxt[9:0]);
    return (s > MAX_MS) ? MAX_MS : s;
  endfunction

  // Reference LFSR tracking the DUT's free-running generator
  always @(posedge clk) begin
    if (reset) m_lfsr <= 11'h001;
    else       m_lfsr <= m_step(m_lfsr);
  end

  // Countdown timer model sitting between the controller's strobes and timer_value
  always @(posedge clk) begin
    if (reset) begin
      timer_value <= '0;
      m_presc     <= 2'd0;
    end else if (timer_stop) begin
      timer_value <= timer_start;
      m_presc     <= 2'd0;
    end else if (timer_enable) begin
      if (m_presc == 2'd3) begin
        m_presc <= 2'd0;
        if (timer_value != '0) timer_value <= timer_value - 6'd1;
      end else begin
        m_presc <= m_presc + 2'd1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an ARM strobe or a result
  always @(negedge clk) begin
    int   e;
    res_t r;
    if (timer_stop) begin
      if (arm_q.size() == 0) begin
        chk("arm_unexpected", 1, 0);
      end else begin
        e = arm_q.pop_front();
        chk("arm_start", int'(timer_start), e);
        chk("arm_range", int'(timer_start >= 6'd2 && timer_start <= 6'd63), 1);
      end
    end
    if (result_valid) begin
      if (res_q.size() == 0) begin
        chk("result_unexpected", 1, 0);
      end else begin
        r = res_q.pop_front();
        chk("result_ms", int'(reaction_ms), r.ms);
        chk("result_timeout", int'(timeout), r.to);
      end
    end
    if (led_forbid) chk("led_in_foul_run", int'(led_on), 0);
  end

  task automatic press();
    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
  endtask

  task automatic arm();
    arm_q.push_back(exp_start(m_lfsr));
    press();
  endtask

  task automatic wait_led(output int n);
    n = 0;
    while (!led_on && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("led_reached", int'(led_on), 1);
  endtask

  task automatic chk_quiet(input string name);
    chk(name, int'({timer_stop, timer_enable, led_on, result_valid, too_early, timeout}), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int n;
    reset  = 1'b1;
    button = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset_outs");
    chk("reset_reaction_ms", int'(reaction_ms), 0);
    chk("reset_timer_start", int'(timer_start), 0);
    reset = 1'b0;
    @(negedge clk);
    chk_quiet("idle_outs");

    // Normal round: ARM strobe, WAIT, lamp, press 20 cycles into REACT -> 5 ms
    arm();
    chk("arm_stop", int'(timer_stop), 1);
    chk("arm_enable", int'(timer_enable), 0);
    @(negedge clk);
    chk("wait_enable", int'(timer_enable), 1);
    chk("wait_stop", int'(timer_stop), 0);
    wait_led(n);
    chk("react_timer_zero", int'(timer_value), 0);
    chk("react_enable", int'(timer_enable), 0);
    repeat (20) @(negedge clk);
    res_q.push_back('{5, 0});
    press();
    chk("show_led", int'(led_on), 0);
    repeat (3) @(negedge clk);
    chk("show_hold_ms", int'(reaction_ms), 5);
    press();
    chk_quiet("idle_after_show");

    // Early press well before expiry
    arm();
    led_forbid = 1'b1;
    repeat (3) @(negedge clk);
    press();
    chk("foul_too_early", int'(too_early), 1);
    chk("foul_enable", int'(timer_enable), 0);
    repeat (5) @(negedge clk);
    press();
    chk("foul_exit", int'(too_early), 0);

    // Press in the exact cycle timer_value reads zero: press wins
    arm();
    @(negedge clk);
    n = 0;
    while (timer_value != '0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("zero_reached", int'(timer_value), 0);
    press();
    chk("zero_press_foul", int'(too_early), 1);
    repeat (2) @(negedge clk);
    press();
    chk_quiet("zero_press_idle");
    led_forbid = 1'b0;

    // No press: saturation at MAX_MS after exactly 63*4 REACT cycles
    arm();
    wait_led(n);
    res_q.push_back('{MAX_MS, 1});
    n = 0;
    while (!result_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", n, MAX_MS * CPM + 1);
    repeat (3) @(negedge clk);
    chk("timeout_hold", int'(timeout), 1);
    chk("timeout_ms_hold", int'(reaction_ms), MAX_MS);
    chk("timeout_led", int'(led_on), 0);
    press();
    chk("timeout_cleared", int'(timeout), 0);

    // Press coinciding with saturation counts as a press
    arm();
    wait_led(n);
    repeat (MAX_MS * CPM) @(negedge clk);
    res_q.push_back('{MAX_MS, 0});
    press();
    chk("sat_press_timeout", int'(timeout), 0);
    press();

    // Reset in REACT together with a press: back to IDLE, all outputs cleared
    arm();
    wait_led(n);
    repeat (10) @(negedge clk);
    reset  = 1'b1;
    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    reset  = 1'b0;
    chk_quiet("reset_react_outs");
    chk("reset_react_ms", int'(reaction_ms), 0);
    chk("reset_react_start", int'(timer_start), 0);
    @(negedge clk);
    chk("reset_no_arm", int'(timer_stop), 0);

    // LFSR sweep: 2047 ARM samples, each timer_start predicted by the model
    for (int i = 0; i < 2047; i++) begin
      arm();
      @(negedge clk);
      press();
      press();
    end

    repeat (3) @(negedge clk);
    chk("arm_queue_empty", arm_q.size(), 0);
    chk("result_queue_empty", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
